i2s_frame_sched: RTL and testbench
==================================

// Module: i2s_frame_sched
// PURPOSE
//  Stereo frame scheduler that sequences the I2S master's SMP input. Upstream producers (SID
//  mixer) push {left,right} frames through a valid/ready FIFO. The block presents exactly one
//  channel per I2S load slot: left, then right of the same frame. Stereo coherence is
//  guaranteed, and underrun/mute are handled cleanly.
// PARAMETERS
//  DEPTH      4   frame FIFO depth in frames; power of 2, >= 2
//  HOLD_LAST  1   on underrun: 1 = repeat last popped frame, 0 = output zero frame
// PORTS
//  CLK        in   1          system clock (12 MHz, same clock as I2S master)
//  RST        in   1          reset, asynchronous, active-high
//  IN_VALID   in   1          upstream frame valid
//  IN_READY   out  1          FIFO can accept a frame (combinational: count != DEPTH)
//  IN_LEFT    in   16 signed  left sample, two's complement
//  IN_RIGHT   in   16 signed  right sample, two's complement
//  SAMPLED    in   1          1-cycle pulse from I2S master; SMP was loaded on the previous edge
//  LCK        in   1          I2S word clock from master; 0 = left slot, 1 = right slot
//  MUTE       in   1          force zero output, applied at frame boundary
//  SMP        out  16 signed  sample to I2S master (registered)
//  SYNCED     out  1          1 once aligned to the LCK frame
//  LEVEL      out  log2(DEPTH)+1  frames currently held in the FIFO
//  UNDERRUNS  out  8          saturating count of frame pops from an empty FIFO
// BEHAVIOUR
//  Reset (async): SMP=0, SYNCED=0, LEVEL=0, UNDERRUNS=0, FIFO empty, state=SYNC.
//   Last frame is cleared to 0. Pushes are ignored while RST is high.
//  Push: a frame is written when IN_VALID & IN_READY on the CLK edge.
//   No bypass: a frame pushed in a cycle is poppable from the next cycle on.
//  Slot timing: the master latches SMP one cycle before SAMPLED; load slots are 128 CLK apart.
//   LCK alternates per slot. SMP updates on the edge after SAMPLED and is stable 127 cycles.
//  States:
//   SYNC:   SMP=0. On SAMPLED & LCK=1 (right slot just loaded): pop frame, SMP<=left,
//           SYNCED<=1 -> WAIT_L. SAMPLED & LCK=0 is ignored.
//   WAIT_L: left is presented. On SAMPLED & LCK=0: SMP<=right of the same frame -> WAIT_R.
//           On SAMPLED & LCK=1 (slip): SYNCED<=0, SMP<=0 -> SYNC.
//   WAIT_R: right is presented. On SAMPLED & LCK=1: pop next frame, SMP<=its left -> WAIT_L.
//           On SAMPLED & LCK=0 (slip): SYNCED<=0, SMP<=0 -> SYNC.
//  Pop:
//   FIFO non-empty: take the head frame and store it as the last frame.
//   FIFO empty (underrun): use the last frame if HOLD_LAST=1, else zero.
//    UNDERRUNS+1, saturating at 255. The FIFO pointers are unchanged.
//  Simultaneous push and pop:
//   Both occur. LEVEL is unchanged if the FIFO is non-empty.
//   If the FIFO was empty, the pop underruns and LEVEL becomes 1.
//  MUTE is sampled only at pop. If high, the frame is still consumed (FIFO drains, underruns
//   still counted) but both channels of that frame output 0. A mid-frame MUTE change never
//   splits a frame.
//  Full FIFO: IN_READY=0, the upstream frame is held, and no frame is lost.
//   Pointers wrap mod DEPTH; LEVEL ranges 0..DEPTH.
//  RST asserted mid-frame: immediate return to reset values. After release, the block
//   re-syncs on the next right-slot SAMPLED.
// TESTING
//  1 Reset, push (0x1234,0xABCD) and (0x0001,0xFFFF), run master -> SMP sequence
//    0x1234,0xABCD,0x0001,0xFFFF, each changing 1 cycle after SAMPLED.
//  2 Push DEPTH+2 frames with no slots -> IN_READY=0 after 4 pushes, LEVEL=4, held frame
//    accepted after the first pop.
//  3 Empty FIFO after frame (0x7FFF,0x8000), HOLD_LAST=1 -> repeats 0x7FFF/0x8000 and
//    UNDERRUNS increments per frame; with HOLD_LAST=0 -> 0/0.
//  4 300 underrun frames -> UNDERRUNS=255, no wrap.
//  5 MUTE raised while right slot is pending -> current right still output, next frame 0/0,
//    LEVEL decrements.
//  6 RST pulsed mid-WAIT_R, and a forced LCK slip -> SMP=0, SYNCED=0, re-aligned at the
//    next LCK=1 SAMPLED.

Source files
------------

// File: rtl/i2s_frame_sched.sv
// Stereo frame scheduler: buffers {left,right} frames and presents one channel per I2S load slot.
// Latency: a pushed frame is poppable the next cycle; SMP updates one cycle after SAMPLED.
// Backpressure: in_ready_o drops while the frame FIFO holds DEPTH frames; upstream holds its frame.
module i2s_frame_sched #(
  parameter int DEPTH     = 4,
  parameter bit HOLD_LAST = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [15:0]              in_left_i,
  input  logic [15:0]              in_right_i,
  input  logic                     sampled_i,
  input  logic                     lck_i,
  input  logic                     mute_i,
  output logic [15:0]              smp_o,
  output logic                     synced_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [7:0]               underruns_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_WAIT_L = 2'd1,
    ST_WAIT_R = 2'd2
  } state_t;

  // Frame storage, one array per channel
  logic [15:0] mem_l [DEPTH];
  logic [15:0] mem_r [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  state_t        state_q, state_d;
  logic [15:0]   smp_q, smp_d;
  logic [15:0]   right_q, right_d;     // right channel of the frame currently being presented
  logic [15:0]   last_l_q, last_l_d;   // last frame actually taken from the FIFO
  logic [15:0]   last_r_q, last_r_d;
  logic          synced_q, synced_d;
  logic [7:0]    und_q, und_d;

  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic [15:0]   pop_l;
  logic [15:0]   pop_r;

  assign fifo_empty  = (count_q == '0);
  assign in_ready_o  = (count_q != FULL_CNT);
  assign push        = in_valid_i & in_ready_o;

  assign smp_o       = smp_q;
  assign synced_o    = synced_q;
  assign level_o     = count_q;
  assign underruns_o = und_q;

  // Frame a pop would deliver this cycle: head, or underrun substitute; mute zeroes both channels
  always_comb begin
    pop_l = '0;
    pop_r = '0;
    if (!fifo_empty) begin
      pop_l = mem_l[rd_ptr_q];
      pop_r = mem_r[rd_ptr_q];
    end else if (HOLD_LAST) begin
      pop_l = last_l_q;
      pop_r = last_r_q;
    end
    if (mute_i) begin
      pop_l = '0;
      pop_r = '0;
    end
  end

  // Slot sequencer: left on a right-slot load, then right of the same frame; any slip re-syncs
  always_comb begin
    state_d  = state_q;
    smp_d    = smp_q;
    synced_d = synced_q;
    right_d  = right_q;
    pop      = 1'b0;
    case (state_q)
      ST_SYNC: begin
        if (sampled_i && lck_i) begin
          pop      = 1'b1;
          smp_d    = pop_l;
          right_d  = pop_r;
          synced_d = 1'b1;
          state_d  = ST_WAIT_L;
        end
      end
      ST_WAIT_L: begin
        if (sampled_i) begin
          if (!lck_i) begin
            smp_d   = right_q;
            state_d = ST_WAIT_R;
          end else begin
            smp_d    = '0;
            synced_d = 1'b0;
            state_d  = ST_SYNC;
          end
        end
      end
      ST_WAIT_R: begin
        if (sampled_i) begin
          if (lck_i) begin
            pop     = 1'b1;
            smp_d   = pop_l;
            right_d = pop_r;
            state_d = ST_WAIT_L;
          end else begin
            smp_d    = '0;
            synced_d = 1'b0;
            state_d  = ST_SYNC;
          end
        end
      end
      default: begin
        smp_d    = '0;
        synced_d = 1'b0;
        state_d  = ST_SYNC;
      end
    endcase
  end

  // FIFO pointers, occupancy, last-frame capture and underrun accounting
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_l_d = last_l_q;
    last_r_d = last_r_q;
    und_d    = und_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop && !fifo_empty) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      last_l_d = mem_l[rd_ptr_q];
      last_r_d = mem_r[rd_ptr_q];
    end
    if (pop && fifo_empty && (und_q != 8'hFF)) begin
      und_d = und_q + 8'd1;
    end
    // An underrunning pop does not consume, so a same-cycle push still raises the level
    case ({push, pop && !fifo_empty})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Frame storage write; pointers guard against use while reset is held
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      mem_l[wr_ptr_q] <= in_left_i;
      mem_r[wr_ptr_q] <= in_right_i;
    end
  end

  // State and bookkeeping registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_SYNC;
      smp_q    <= '0;
      synced_q <= 1'b0;
      right_q  <= '0;
      last_l_q <= '0;
      last_r_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      und_q    <= '0;
    end else begin
      state_q  <= state_d;
      smp_q    <= smp_d;
      synced_q <= synced_d;
      right_q  <= right_d;
      last_l_q <= last_l_d;
      last_r_q <= last_r_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      und_q    <= und_d;
    end
  end

endmodule

// File: tb/tb_i2s_frame_sched.sv
// Bench for i2s_frame_sched: a hold-last and a zero-fill instance share all inputs.
// Expected slot outputs come from a frame-level reference model and are queued for a monitor.
// Stimulus mixes directed scenarios with a randomized producer, mute and slot slips.
module tb_i2s_frame_sched;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } frame_t;

  typedef struct {
    logic [15:0] h;
    logic [15:0] z;
    logic        syn;
    logic [7:0]  und;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_left = '0;
  logic [15:0] in_right = '0;
  logic        sampled = 1'b0;
  logic        lck = 1'b0;
  logic        mute = 1'b0;
  logic        in_ready_h, in_ready_z, synced_h, synced_z;
  logic [15:0] smp_h, smp_z;
  logic [2:0]  level_h, level_z;
  logic [7:0]  und_h, und_z;

  int n_checks = 0;
  int n_pass = 0;

  // Reference model state
  frame_t mq[$];
  frame_t src[$];
  exp_t   sb[$];
  frame_t m_last, m_cur_h, m_cur_z;
  logic [15:0] m_out_h, m_out_z;
  logic   m_sync;
  logic   m_next_lck;
  int     m_und;

  // Producer and master state
  logic   pv = 1'b0;
  frame_t pf = '0;
  int     prod_rate = 0;
  logic   rst_next = 1'b0;
  logic   mlck = 1'b0;
  logic [15:0] mon_h = '0, mon_z = '0;

  always #5 clk = ~clk;

  i2s_frame_sched #(.DEPTH(DEPTH), .HOLD_LAST(1'b1)) u_hold (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_h),
    .in_left_i(in_left), .in_right_i(in_right), .sampled_i(sampled), .lck_i(lck),
    .mute_i(mute), .smp_o(smp_h), .synced_o(synced_h), .level_o(level_h), .underruns_o(und_h));

  i2s_frame_sched #(.DEPTH(DEPTH), .HOLD_LAST(1'b0)) u_zero (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_z),
    .in_left_i(in_left), .in_right_i(in_right), .sampled_i(sampled), .lck_i(lck),
    .mute_i(mute), .smp_o(smp_z), .synced_o(synced_z), .level_o(level_z), .underruns_o(und_z));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    m_last = '0; m_cur_h = '0; m_cur_z = '0;
    m_out_h = '0; m_out_z = '0;
    m_sync = 1'b0; m_next_lck = 1'b1; m_und = 0;
  endtask

  // One frame consumption: head if any, else the underrun substitute per variant
  task automatic model_pop(input logic mt);
    if (mq.size() > 0) begin
      m_last  = mq.pop_front();
      m_cur_h = m_last;
      m_cur_z = m_last;
    end else begin
      if (m_und < 255) m_und++;
      m_cur_h = m_last;
      m_cur_z = '0;
    end
    if (mt) begin
      m_cur_h = '0;
      m_cur_z = '0;
    end
  endtask

  // A load slot: right-slot loads start frames, left-slot loads finish them, anything else slips
  task automatic model_slot(input logic lk, input logic mt);
    exp_t e;
    if (!m_sync) begin
      if (lk) begin
        model_pop(mt);
        m_sync = 1'b1; m_next_lck = 1'b0;
        m_out_h = m_cur_h.l; m_out_z = m_cur_z.l;
      end
    end else if (lk != m_next_lck) begin
      m_sync = 1'b0; m_next_lck = 1'b1;
      m_out_h = '0; m_out_z = '0;
    end else if (!lk) begin
      m_out_h = m_cur_h.r; m_out_z = m_cur_z.r;
      m_next_lck = 1'b1;
    end else begin
      model_pop(mt);
      m_next_lck = 1'b0;
      m_out_h = m_cur_h.l; m_out_z = m_cur_z.l;
    end
    e.h = m_out_h; e.z = m_out_z; e.syn = m_sync; e.und = 8'(m_und);
    sb.push_back(e);
  endtask

  // One clock of stimulus; the model describes what the next rising edge does
  task automatic tick(input logic ev, input logic lk, input logic mt);
    logic rdy;
    @(negedge clk); #1;
    chk("level_hold", 32'(level_h), 32'(mq.size()));
    chk("level_zero", 32'(level_z), 32'(mq.size()));
    chk("in_ready", 32'(in_ready_h), 32'(mq.size() < DEPTH));
    rdy = (mq.size() < DEPTH);
    if (!pv && src.size() > 0 && $urandom_range(99) < prod_rate) begin
      pv = 1'b1;
      pf = src.pop_front();
    end
    rst = rst_next;
    in_valid = pv; in_left = pf.l; in_right = pf.r;
    sampled = ev; lck = lk; mute = mt;
    if (rst) begin
      model_reset();
    end else begin
      if (ev) model_slot(lk, mt);
      if (pv && rdy) begin
        mq.push_back(pf);
        pv = 1'b0;
      end
    end
  endtask

  task automatic slot(input int len, input logic lk, input logic mt);
    repeat (len - 1) tick(1'b0, lk, mt);
    tick(1'b1, lk, mt);
    tick(1'b0, lk, mt);
  endtask

  task automatic next_slot(input int len, input logic mt);
    mlck = ~mlck;
    slot(len, mlck, mt);
  endtask

  // Monitor: compares at each falling edge; slot results come from the scoreboard
  initial begin
    logic fire;
    exp_t e;
    forever begin
      @(posedge clk);
      fire = sampled && !rst;
      @(negedge clk);
      if (rst) begin
        mon_h = '0; mon_z = '0;
        chk("rst_smp", 32'(smp_h), 32'h0);
        chk("rst_synced", 32'(synced_h), 32'h0);
      end else if (fire) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL sb_empty: slot output seen with no expectation queued");
        end else begin
          e = sb.pop_front();
          chk("slot_smp_hold", 32'(smp_h), 32'(e.h));
          chk("slot_smp_zero", 32'(smp_z), 32'(e.z));
          chk("slot_synced", 32'(synced_h), 32'(e.syn));
          chk("slot_synced_z", 32'(synced_z), 32'(e.syn));
          chk("slot_underruns", 32'(und_h), 32'(e.und));
          chk("slot_underruns_z", 32'(und_z), 32'(e.und));
          mon_h = e.h; mon_z = e.z;
        end
      end else begin
        chk("smp_stable_hold", 32'(smp_h), 32'(mon_h));
        chk("smp_stable_zero", 32'(smp_z), 32'(mon_z));
      end
    end
  end

  initial begin
    int ub;
    model_reset();
    #1 rst = 1'b1;
    rst_next = 1'b1;
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    chk("reset_smp", 32'(smp_h), 32'h0);
    chk("reset_synced", 32'(synced_h), 32'h0);
    chk("reset_level", 32'(level_h), 32'h0);
    chk("reset_underruns", 32'(und_h), 32'h0);
    rst_next = 1'b0;

    // Two frames then a master run starting on an ignored left slot
    src.push_back({16'h1234, 16'hABCD});
    src.push_back({16'h0001, 16'hFFFF});
    prod_rate = 100;
    mlck = 1'b1;
    repeat (5) next_slot(6, 1'b0);
    chk("t1_last_right", 32'(smp_h), 32'h0000FFFF);
    chk("t1_synced", 32'(synced_h), 32'h1);

    // Overfill with no slots: FIFO caps at DEPTH, held frame enters after the first pop
    for (int i = 0; i < DEPTH + 2; i++) src.push_back(frame_t'($urandom()));
    repeat (12) tick(1'b0, mlck, 1'b0);
    chk("t2_full_ready", 32'(in_ready_h), 32'h0);
    chk("t2_full_level", 32'(level_h), 32'd4);
    repeat (16) next_slot(5, 1'b0);

    // Hold-last versus zero-fill underrun
    src.push_back({16'h7FFF, 16'h8000});
    repeat (2) next_slot(5, 1'b0);
    ub = m_und;
    repeat (4) next_slot(5, 1'b0);
    chk("t3_hold_right", 32'(smp_h), 32'h00008000);
    chk("t3_zero_right", 32'(smp_z), 32'h0);
    chk("t3_underruns", 32'(und_h), 32'(ub + 2));

    // Long underrun run saturates the counter
    repeat (600) next_slot(3, 1'b0);
    chk("t4_saturated", 32'(und_h), 32'd255);

    // Mute raised with a right slot pending
    if (m_next_lck) next_slot(4, 1'b0);
    src.push_back({16'h1111, 16'h2222});
    src.push_back({16'h3333, 16'h4444});
    src.push_back({16'h5555, 16'h6666});
    next_slot(8, 1'b0);
    next_slot(8, 1'b0);
    chk("t5_left_a", 32'(smp_h), 32'h1111);
    next_slot(8, 1'b1);
    chk("t5_right_a", 32'(smp_h), 32'h2222);
    next_slot(8, 1'b1);
    chk("t5_muted_left", 32'(smp_h), 32'h0);
    chk("t5_level", 32'(level_h), 32'd1);
    next_slot(8, 1'b0);
    chk("t5_muted_right", 32'(smp_h), 32'h0);
    next_slot(8, 1'b0);
    chk("t5_left_c", 32'(smp_h), 32'h5555);

    // Reset in the middle of a right slot, then a forced slip
    next_slot(6, 1'b0);
    repeat (3) tick(1'b0, mlck, 1'b0);
    rst_next = 1'b1;
    repeat (2) tick(1'b0, mlck, 1'b0);
    rst_next = 1'b0;
    tick(1'b0, mlck, 1'b0);
    chk("t6_rst_smp", 32'(smp_h), 32'h0);
    chk("t6_rst_synced", 32'(synced_h), 32'h0);
    next_slot(6, 1'b0);
    chk("t6_resynced", 32'(synced_h), 32'h1);
    slot(6, mlck, 1'b0);
    chk("t6_slip_synced", 32'(synced_h), 32'h0);
    chk("t6_slip_smp", 32'(smp_h), 32'h0);
    slot(6, mlck, 1'b0);
    chk("t6_slip_resync", 32'(synced_h), 32'h1);

    // Randomized traffic, mute and occasional slips
    for (int i = 0; i < 80; i++) src.push_back(frame_t'($urandom()));
    prod_rate = 40;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(99) >= 5) mlck = ~mlck;
      slot($urandom_range(12, 3), mlck, ($urandom_range(99) < 15));
    end

    repeat (4) tick(1'b0, mlck, 1'b0);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
